// File: rtl/wsbn_bus_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole CYC burst, watchdog ERR on missing ACK.
// Latency: grant 1 cycle after a request is sampled in IDLE; bus mux and ACK routing are combinational.
// Backpressure: the losing master waits with cyc raised until the owner drops cyc; no request is queued.
module wsbn_bus_arbiter #(
  parameter int ADR_W   = 8,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cyc_m0,
  input  logic             stb_m0,
  input  logic             we_m0,
  input  logic [ADR_W-1:0] adr_m0,
  input  logic [DAT_W-1:0] dat_m0,
  output logic             ack_m0,
  output logic             err_m0,
  input  logic             cyc_m1,
  input  logic             stb_m1,
  input  logic             we_m1,
  input  logic [ADR_W-1:0] adr_m1,
  input  logic [DAT_W-1:0] dat_m1,
  output logic             ack_m1,
  output logic             err_m1,
  output logic [1:0]       gnt_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  input  logic             ack_i
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last;      // master that most recently released the bus (0 = M0, 1 = M1)
  logic            last_nxt;
  logic [WD_W-1:0] wdog;
  logic            fire;

  // Next-state logic: tie in IDLE goes to the master that did not hold the bus last.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (cyc_m0 && cyc_m1) state_nxt = last ? GNT0 : GNT1;
        else if (cyc_m0)      state_nxt = GNT0;
        else if (cyc_m1)      state_nxt = GNT1;
      end
      GNT0: begin
        if (!cyc_m0) begin
          state_nxt = IDLE;
          last_nxt  = 1'b0;
        end
      end
      GNT1: begin
        if (!cyc_m1) begin
          state_nxt = IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and round-robin pointer; reset makes M0 win the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  assign gnt_o = {state == GNT1, state == GNT0};

  // Bus outputs follow the granted master; everything is zero in IDLE (and therefore during reset).
  always_comb begin
    cyc_o = 1'b0;
    stb_o = 1'b0;
    we_o  = 1'b0;
    adr_o = '0;
    dat_o = '0;
    if (state == GNT0) begin
      cyc_o = cyc_m0;
      stb_o = stb_m0;
      we_o  = we_m0;
      adr_o = adr_m0;
      dat_o = dat_m0;
    end else if (state == GNT1) begin
      cyc_o = cyc_m1;
      stb_o = stb_m1;
      we_o  = we_m1;
      adr_o = adr_m1;
      dat_o = dat_m1;
    end
  end

  // The error pulse cycle suppresses ACK so a master never sees both at once.
  assign ack_m0 = gnt_o[0] & stb_o & ack_i & ~err_m0;
  assign ack_m1 = gnt_o[1] & stb_o & ack_i & ~err_m1;

  assign fire = (state != IDLE) && stb_o && !ack_i && (wdog == WD_W'(TIMEOUT - 1));

  // Watchdog counts consecutive strobed cycles without ACK; clears on fire so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog <= '0;
    end else if (state == IDLE || !stb_o || ack_i || fire) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + WD_W'(1);
    end
  end

  // One-cycle error pulse to the master that owned the timed-out strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_m0 <= 1'b0;
      err_m1 <= 1'b0;
    end else begin
      err_m0 <= fire & gnt_o[0];
      err_m1 <= fire & gnt_o[1];
    end
  end

endmodule

// File: tb/tb_wsbn_bus_arbiter.sv
// Randomized bench for wsbn_bus_arbiter with a scoreboard queue and an independent reference model.
// Stimulus is applied 2 time units after each rising edge; the monitor compares on the falling edge.
// Includes reset with both requests raised and asynchronous resets in the middle of traffic.
module tb_wsbn_bus_arbiter;

  localparam int ADR_W   = 8;
  localparam int DAT_W   = 32;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cyc_m0 = 1'b0, stb_m0 = 1'b0, we_m0 = 1'b0;
  logic [ADR_W-1:0] adr_m0 = '0;
  logic [DAT_W-1:0] dat_m0 = '0;
  logic             cyc_m1 = 1'b0, stb_m1 = 1'b0, we_m1 = 1'b0;
  logic [ADR_W-1:0] adr_m1 = '0;
  logic [DAT_W-1:0] dat_m1 = '0;
  logic             ack_i = 1'b0;
  logic             ack_m0, err_m0, ack_m1, err_m1;
  logic [1:0]       gnt_o;
  logic             cyc_o, stb_o, we_o;
  logic [ADR_W-1:0] adr_o;
  logic [DAT_W-1:0] dat_o;

  wsbn_bus_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cyc_m0(cyc_m0), .stb_m0(stb_m0), .we_m0(we_m0), .adr_m0(adr_m0), .dat_m0(dat_m0),
    .ack_m0(ack_m0), .err_m0(err_m0),
    .cyc_m1(cyc_m1), .stb_m1(stb_m1), .we_m1(we_m1), .adr_m1(adr_m1), .dat_m1(dat_m1),
    .ack_m1(ack_m1), .err_m1(err_m1),
    .gnt_o(gnt_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       gnt;
    logic             cyc, stb, we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic             ack0, ack1, err0, err1;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: who owns the bus, who wins the next tie, length of the unacked strobe run.
  int owner    = -1;
  int prefer   = 0;
  int streak   = 0;
  int err_pend = -1;
  int n_err    = 0;
  int n_ack    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  task automatic model_reset();
    owner = -1; prefer = 0; streak = 0; err_pend = -1;
  endtask

  // Expected outputs for the current cycle from model state and the inputs just driven.
  task automatic model_expect(output exp_t e);
    logic s;
    e = '{gnt: 2'b00, cyc: 1'b0, stb: 1'b0, we: 1'b0, adr: '0, dat: '0,
          ack0: 1'b0, ack1: 1'b0, err0: 1'b0, err1: 1'b0};
    if (owner == 0) begin
      e.gnt = 2'b01; e.cyc = cyc_m0; e.stb = stb_m0; e.we = we_m0; e.adr = adr_m0; e.dat = dat_m0;
    end else if (owner == 1) begin
      e.gnt = 2'b10; e.cyc = cyc_m1; e.stb = stb_m1; e.we = we_m1; e.adr = adr_m1; e.dat = dat_m1;
    end
    e.err0 = (err_pend == 0);
    e.err1 = (err_pend == 1);
    s = e.stb & ack_i;
    e.ack0 = (owner == 0) && s && !e.err0;
    e.ack1 = (owner == 1) && s && !e.err1;
    if (e.err0 || e.err1) n_err++;
    if (e.ack0 || e.ack1) n_ack++;
  endtask

  // Advance the model across one rising edge.
  task automatic model_step();
    logic ostb;
    ostb = (owner == 0) ? stb_m0 : (owner == 1) ? stb_m1 : 1'b0;
    err_pend = -1;
    if (owner >= 0 && ostb && !ack_i) begin
      streak++;
      if (streak == TIMEOUT) begin
        err_pend = owner;
        streak   = 0;
      end
    end else begin
      streak = 0;
    end
    if (owner < 0) begin
      if (cyc_m0 && cyc_m1) owner = prefer;
      else if (cyc_m0)      owner = 0;
      else if (cyc_m1)      owner = 1;
    end else if ((owner == 0 && !cyc_m0) || (owner == 1 && !cyc_m1)) begin
      prefer = 1 - owner;
      owner  = -1;
    end
  endtask

  // Monitor: compare the DUT against the oldest expected record each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt_o",  64'(gnt_o),  64'(e.gnt));
        chk("cyc_o",  64'(cyc_o),  64'(e.cyc));
        chk("stb_o",  64'(stb_o),  64'(e.stb));
        chk("we_o",   64'(we_o),   64'(e.we));
        chk("adr_o",  64'(adr_o),  64'(e.adr));
        chk("dat_o",  64'(dat_o),  64'(e.dat));
        chk("ack_m0", 64'(ack_m0), 64'(e.ack0));
        chk("ack_m1", 64'(ack_m1), 64'(e.ack1));
        chk("err_m0", 64'(err_m0), 64'(e.err0));
        chk("err_m1", 64'(err_m1), 64'(e.err1));
      end
    end
  end

  // Sticky random master behaviour so bursts and long unacked strobes both occur.
  task automatic drive_master(inout logic cyc, inout logic stb, output logic we,
                              output logic [ADR_W-1:0] adr, output logic [DAT_W-1:0] dat,
                              input int drop_mod);
    if (cyc) cyc = ($urandom % drop_mod) != 0;
    else     cyc = ($urandom % 4) == 0;
    if (!cyc)     stb = 1'b0;
    else if (stb) stb = ($urandom % 16) != 0;
    else          stb = ($urandom % 2) == 0;
    we  = 1'($urandom);
    adr = ADR_W'($urandom);
    dat = DAT_W'($urandom);
  endtask

  task automatic one_cycle(input int ack_pct, input int drop_mod, input bit do_rst);
    exp_t e;
    @(posedge clk);
    #2;
    drive_master(cyc_m0, stb_m0, we_m0, adr_m0, dat_m0, drop_mod);
    drive_master(cyc_m1, stb_m1, we_m1, adr_m1, dat_m1, drop_mod);
    ack_i = ($urandom % 100) < ack_pct;
    rst   = !do_rst;
    if (do_rst) begin
      model_reset();
      #1;
      chk("async_rst_gnt", 64'(gnt_o), 64'd0);
      chk("async_rst_bus", 64'({cyc_o, stb_o, we_o, adr_o, dat_o}), 64'd0);
    end
    model_expect(e);
    exp_q.push_back(e);
    if (!do_rst) model_step();
  endtask

  initial begin
    exp_t e;
    int   ack_pct[4]  = '{50, 10, 0, 30};
    int   drop_mod[4] = '{8, 30, 40, 12};
    // Reset held with both masters requesting: everything must stay quiet.
    rst = 1'b0;
    cyc_m0 = 1'b1; stb_m0 = 1'b1; cyc_m1 = 1'b1; stb_m1 = 1'b1; ack_i = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      model_expect(e);
      exp_q.push_back(e);
    end
    // Release with both requesting: model predicts M0 wins the first tie.
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_expect(e);
    exp_q.push_back(e);
    model_step();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 700; i++) begin
        one_cycle(ack_pct[p], drop_mod[p], (i == 350) || (i == 500 && p == 3));
      end
    end
    // Quiesce and drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain_q", 64'(exp_q.size()), 64'd0);
    if (n_err == 0) begin
      n_tests++; n_fail++;
      $display("FAIL err_coverage: got 0 error pulses expected at least 1");
    end
    if (n_ack == 0) begin
      n_tests++; n_fail++;
      $display("FAIL ack_coverage: got 0 acks expected at least 1");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
